// File: rtl/arith_pkg.sv
// Shared arithmetic package: subtractor FSM states and width helpers.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Ceiling log2 for elaboration-time width calculations (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? (v - 1) : 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((x >> i) != 0) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational ripple chain of N full-subtractor cells.
module sub_slice #(
  parameter int unsigned N = 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic [N:0] brw_c;

  // Ripple the borrow from bit 0 upwards through each cell.
  always_comb begin
    brw_c    = '0;
    diff     = '0;
    brw_c[0] = bin;
    for (int unsigned i = 0; i < N; i++) begin
      diff[i]    = a[i] ^ b[i] ^ brw_c[i];
      brw_c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw_c[i]);
    end
    bout = brw_c[N];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: a - b - bin, BPC bits per clock, start/busy/done handshake.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned NSLICE = (BPC == 0) ? 1 : (WIDTH / BPC);
  localparam int unsigned CW     = cnt_width(NSLICE);

  // Reject operand/slice geometries that cannot be processed in whole slices.
  if (WIDTH < 1 || BPC < 1 || (WIDTH % ((BPC == 0) ? 1 : BPC)) != 0) begin : g_bad_params
    $error("serial_subtractor: BPC must be >= 1 and divide WIDTH (WIDTH=%0d BPC=%0d)", WIDTH, BPC);
  end

  sub_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [BPC-1:0]   sl_diff_c;
  logic             sl_bout_c;
  logic             last_c;

  sub_slice #(.N(BPC)) u_slice (
    .a    (a_q[BPC-1:0]),
    .b    (b_q[BPC-1:0]),
    .bin  (brw_q),
    .diff (sl_diff_c),
    .bout (sl_bout_c)
  );

  assign last_c = (cnt_q == CW'(NSLICE - 1));

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        // Slice result enters diff at the MSB end; operands move down one slice.
        diff_d = WIDTH'({sl_diff_c, diff_q} >> BPC);
        a_d    = a_q >> BPC;
        b_d    = b_q >> BPC;
        brw_d  = sl_bout_c;
        if (last_c) begin
          // Top slice: a_q/b_q[BPC-1] are the original operand sign bits.
          state_d = DONE;
          done_d  = 1'b1;
          bout_d  = sl_bout_c;
          ovf_d   = (a_q[BPC-1] != b_q[BPC-1]) && (sl_diff_c[BPC-1] != a_q[BPC-1]);
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor across several WIDTH/BPC configurations.
module tb_serial_subtractor;

  localparam int NI = 5;
  // Instances: 0:(8,1) 1:(8,2) 2:(8,4) 3:(4,1) 4:(4,4)
  localparam int W_T  [NI] = '{8, 8, 8, 4, 4};
  localparam int NS_T [NI] = '{8, 4, 2, 4, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v [NI];
  logic [7:0] a_v     [NI];
  logic [7:0] b_v     [NI];
  logic       bin_v   [NI];
  logic       busy_v  [NI];
  logic       done_v  [NI];
  logic       bout_v  [NI];
  logic       ovf_v   [NI];
  logic [7:0] diff_v  [NI];
  logic [3:0] d3, d4;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .BPC(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .bin(bin_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .diff(diff_v[0]), .bout(bout_v[0]), .ovf(ovf_v[0]));
  serial_subtractor #(.WIDTH(8), .BPC(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .bin(bin_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .diff(diff_v[1]), .bout(bout_v[1]), .ovf(ovf_v[1]));
  serial_subtractor #(.WIDTH(8), .BPC(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .bin(bin_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .diff(diff_v[2]), .bout(bout_v[2]), .ovf(ovf_v[2]));
  serial_subtractor #(.WIDTH(4), .BPC(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_v[3][3:0]), .b(b_v[3][3:0]), .bin(bin_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .diff(d3), .bout(bout_v[3]), .ovf(ovf_v[3]));
  serial_subtractor #(.WIDTH(4), .BPC(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[4]), .a(a_v[4][3:0]), .b(b_v[4][3:0]), .bin(bin_v[4]),
    .busy(busy_v[4]), .done(done_v[4]), .diff(d4), .bout(bout_v[4]), .ovf(ovf_v[4]));

  assign diff_v[3] = {4'b0, d3};
  assign diff_v[4] = {4'b0, d4};

  // Reference arithmetic straight from the definition of a - b - bin.
  function automatic logic [7:0] f_diff(input int w, input logic [7:0] a, input logic [7:0] b, input logic bn);
    int r;
    r = int'(a) - int'(b) - int'(bn);
    return 8'(r & ((1 << w) - 1));
  endfunction

  function automatic logic f_bout(input int w, input logic [7:0] a, input logic [7:0] b, input logic bn);
    int am, bm;
    am = int'(a) & ((1 << w) - 1);
    bm = int'(b) & ((1 << w) - 1);
    return (am < bm + int'(bn));
  endfunction

  function automatic logic f_ovf(input int w, input logic [7:0] a, input logic [7:0] b, input logic bn);
    logic [7:0] d;
    d = f_diff(w, a, b, bn);
    return (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: remaining busy cycles and the pending/published result.
  int         m_cnt  [NI];
  logic       m_done [NI];
  logic [7:0] m_diff [NI];
  logic       m_bout [NI];
  logic       m_ovf  [NI];
  logic [7:0] p_diff [NI];
  logic       p_bout [NI];
  logic       p_ovf  [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_cnt[i]  <= 0;
        m_done[i] <= 1'b0;
        m_diff[i] <= 8'h00;
        m_bout[i] <= 1'b0;
        m_ovf[i]  <= 1'b0;
        p_diff[i] <= 8'h00;
        p_bout[i] <= 1'b0;
        p_ovf[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (m_cnt[i] > 0) begin
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) begin
            m_done[i] <= 1'b1;
            m_diff[i] <= p_diff[i];
            m_bout[i] <= p_bout[i];
            m_ovf[i]  <= p_ovf[i];
          end else begin
            m_done[i] <= 1'b0;
          end
        end else if (start_v[i]) begin
          m_cnt[i]  <= NS_T[i];
          m_done[i] <= 1'b0;
          p_diff[i] <= f_diff(W_T[i], a_v[i], b_v[i], bin_v[i]);
          p_bout[i] <= f_bout(W_T[i], a_v[i], b_v[i], bin_v[i]);
          p_ovf[i]  <= f_ovf(W_T[i], a_v[i], b_v[i], bin_v[i]);
        end else begin
          m_done[i] <= 1'b0;
        end
      end
    end
  end

  // Cycle compare: handshake always, results whenever the model says not busy.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_cnt[i] > 0));
      chk($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(m_done[i]));
      if (m_cnt[i] == 0) begin
        chk($sformatf("diff[%0d]", i), 32'(diff_v[i]), 32'(m_diff[i]));
        chk($sformatf("bout[%0d]", i), 32'(bout_v[i]), 32'(m_bout[i]));
        chk($sformatf("ovf[%0d]", i),  32'(ovf_v[i]),  32'(m_ovf[i]));
      end
    end
  end

  // Wait (bounded) for done on instance i; lat counts edges from the start edge.
  task automatic wait_done(input int i, inout int lat, inout int bsy);
    while (!done_v[i] && lat < 64) begin
      if (busy_v[i]) bsy++;
      @(negedge clk);
      lat++;
    end
    if (!done_v[i]) chk($sformatf("done_timeout[%0d]", i), 32'(done_v[i]), 32'd1);
  endtask

  task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic bn,
                        output int lat, output int bsy);
    @(negedge clk);
    start_v[i] = 1'b1;
    a_v[i] = a;
    b_v[i] = b;
    bin_v[i] = bn;
    @(negedge clk);
    start_v[i] = 1'b0;
    a_v[i] = 8'($urandom);
    b_v[i] = 8'($urandom);
    bin_v[i] = 1'($urandom);
    lat = 1;
    bsy = 0;
    wait_done(i, lat, bsy);
  endtask

  task automatic rand_ops(input int i, input int n);
    int lat, bsy;
    for (int k = 0; k < n; k++) begin
      run_op(i, 8'($urandom), 8'($urandom), 1'($urandom), lat, bsy);
      chk($sformatf("rand_lat[%0d]", i), 32'(lat), 32'(NS_T[i] + 1));
    end
  endtask

  initial begin
    int lat, bsy, ndone;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      a_v[i] = 8'h00;
      b_v[i] = 8'h00;
      bin_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_done", 32'(done_v[0]), 32'd0);
    chk("rst_diff", 32'(diff_v[0]), 32'h00);
    chk("rst_bout", 32'(bout_v[0]), 32'd0);
    chk("rst_ovf",  32'(ovf_v[0]),  32'd0);
    rst_n = 1'b1;

    // Basic difference, latency and busy length on (8,1).
    run_op(0, 8'h5A, 8'h3C, 1'b0, lat, bsy);
    chk("t1_diff", 32'(diff_v[0]), 32'h1E);
    chk("t1_bout", 32'(bout_v[0]), 32'd0);
    chk("t1_ovf",  32'(ovf_v[0]),  32'd0);
    chk("t1_lat",  32'(lat), 32'd9);
    chk("t1_busy_cycles", 32'(bsy), 32'd8);

    // Unsigned wrap, then signed overflow.
    run_op(0, 8'h00, 8'h01, 1'b0, lat, bsy);
    chk("t2_diff", 32'(diff_v[0]), 32'hFF);
    chk("t2_bout", 32'(bout_v[0]), 32'd1);
    chk("t2_ovf",  32'(ovf_v[0]),  32'd0);
    run_op(0, 8'h80, 8'h01, 1'b0, lat, bsy);
    chk("t2b_diff", 32'(diff_v[0]), 32'h7F);
    chk("t2b_bout", 32'(bout_v[0]), 32'd0);
    chk("t2b_ovf",  32'(ovf_v[0]),  32'd1);

    // Borrow-in across slices on (8,4).
    run_op(2, 8'h10, 8'h0F, 1'b1, lat, bsy);
    chk("t3_diff", 32'(diff_v[2]), 32'h00);
    chk("t3_bout", 32'(bout_v[2]), 32'd0);
    chk("t3_lat",  32'(lat), 32'd3);

    // Start while busy is ignored; start in DONE begins the next op at once (8,2).
    @(negedge clk);
    start_v[1] = 1'b1; a_v[1] = 8'h5A; b_v[1] = 8'h3C; bin_v[1] = 1'b0;
    @(negedge clk);
    start_v[1] = 1'b0;
    @(negedge clk);
    start_v[1] = 1'b1; a_v[1] = 8'hFF; b_v[1] = 8'h00; bin_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    lat = 3; bsy = 0;
    wait_done(1, lat, bsy);
    chk("t4_lat",  32'(lat), 32'd5);
    chk("t4_diff", 32'(diff_v[1]), 32'h1E);
    chk("t4_busy_in_done", 32'(busy_v[1]), 32'd0);
    start_v[1] = 1'b1; a_v[1] = 8'h00; b_v[1] = 8'h01; bin_v[1] = 1'b0;
    @(negedge clk);
    start_v[1] = 1'b0;
    chk("t4_b2b_busy", 32'(busy_v[1]), 32'd1);
    chk("t4_b2b_done", 32'(done_v[1]), 32'd0);
    lat = 1; bsy = 0;
    wait_done(1, lat, bsy);
    chk("t4_b2b_diff", 32'(diff_v[1]), 32'hFF);
    chk("t4_b2b_bout", 32'(bout_v[1]), 32'd1);

    // Asynchronous reset during the third RUN cycle.
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 8'h5A; b_v[0] = 8'h3C; bin_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy_before", 32'(busy_v[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy_v[0]), 32'd0);
    chk("t5_done", 32'(done_v[0]), 32'd0);
    chk("t5_diff", 32'(diff_v[0]), 32'h00);
    chk("t5_bout", 32'(bout_v[0]), 32'd0);
    chk("t5_ovf",  32'(ovf_v[0]),  32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 32'd0);
    run_op(0, 8'h80, 8'h01, 1'b0, lat, bsy);
    chk("t5_after_diff", 32'(diff_v[0]), 32'h7F);
    chk("t5_after_ovf",  32'(ovf_v[0]),  32'd1);

    // Exhaustive W=4 for BPC=1 and BPC=4.
    fork
      begin
        int l3, b3;
        for (int x = 0; x < 512; x++) begin
          run_op(3, 8'(x & 15), 8'((x >> 4) & 15), 1'(x >> 8), l3, b3);
        end
      end
      begin
        int l4, b4;
        for (int x = 0; x < 512; x++) begin
          run_op(4, 8'(x & 15), 8'((x >> 4) & 15), 1'(x >> 8), l4, b4);
          chk("t6_w4_lat", 32'(l4), 32'd2);
        end
      end
    join

    // Random operands on the 8-bit configurations.
    fork
      rand_ops(0, 120);
      rand_ops(1, 150);
      rand_ops(2, 200);
    join

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
